// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared load/store opcodes, data-side address map and memory-stage states
package rv32i_pkg;

   // Load/store operation keyed by {we, funct3} so loads and stores with equal funct3 stay distinct
   typedef enum logic [3:0] {
      LB  = 4'b0_000,
      LH  = 4'b0_001,
      LW  = 4'b0_010,
      LBU = 4'b0_100,
      LHU = 4'b0_101,
      SB  = 4'b1_000,
      SH  = 4'b1_001,
      SW  = 4'b1_010
   } mem_funct3_e;

   localparam logic [31:0] SW_ADDR  = 32'h0010_0000;
   localparam logic [31:0] LED_ADDR = 32'h0010_0004;
   localparam logic [31:0] CNT_ADDR = 32'h0010_0008;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } dmio_state_e;

endpackage

// File: rtl/data_mem_io_if.sv
// rtl/data_mem_io_if.sv - request/response bundle between control unit and data memory stage
interface data_mem_io_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_io_switch_sync.sv
// rtl/data_mem_io_switch_sync.sv - two-flop synchronizer for asynchronous board inputs
module switch_sync #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   // First flop absorbs metastability, second presents a settled value
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/data_mem_io.sv
// rtl/data_mem_io.sv - data RAM plus switch/LED/counter I/O; DATA_MEM_IO_CYCLE_CNT_EN enables the cycle counter
module data_mem_io
   import rv32i_pkg::*;
#(
   parameter int DMEM_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_io_if.slave      bus,
   input  logic [15:0]       boardSwitches,
   output logic [15:0]       boardLEDs
);
   localparam int AW = $clog2(DMEM_WORDS);
   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_RESP = RESP;

   logic [0:0]    state;
   logic [15:0]   sw_sync;
   logic [15:0]   leds;
   logic [31:0]   dmem [DMEM_WORDS];
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          accept;
   logic [3:0]    op;
   logic [31:0]   word_addr;
   logic [AW-1:0] idx;
   logic          is_ram, is_sw, is_led, is_cnt, cnt_mapped, mapped;
   logic          f3_ok, lane_ok, req_err, wr_ok;
   logic [3:0]    be;
   logic [31:0]   wd, rd_word, sh_word, ld_data, cnt_val;

   switch_sync #(.WIDTH(16)) u_switch_sync (
      .clk (clk),
      .rst (rst),
      .d   (boardSwitches),
      .q   (sw_sync)
   );

`ifdef DATA_MEM_IO_CYCLE_CNT_EN
   logic [31:0] cnt;

   // Free-running cycle counter, wraps silently
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt + 32'd1;
   end

   assign cnt_val    = cnt;
   assign cnt_mapped = is_cnt;
`else
   assign cnt_val    = '0;
   assign cnt_mapped = 1'b0;
`endif

   assign bus.req_ready = (state == ST_IDLE);
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign boardLEDs     = leds;

   assign accept    = bus.req_valid && bus.req_ready;
   assign op        = {bus.req_we, bus.req_funct3};
   assign word_addr = {bus.req_addr[31:2], 2'b00};
   assign idx       = bus.req_addr[AW+1:2];
   assign is_ram    = bus.req_addr < 32'(DMEM_WORDS * 4);
   assign is_sw     = word_addr == SW_ADDR;
   assign is_led    = word_addr == LED_ADDR;
   assign is_cnt    = word_addr == CNT_ADDR;
   assign mapped    = is_ram || is_sw || is_led || cnt_mapped;
   assign req_err   = !f3_ok || !lane_ok || !mapped || (bus.req_we && (is_sw || is_cnt));
   assign wr_ok     = accept && bus.req_we && !req_err;

   // Operation decode: byte lanes, replicated store data and alignment
   always_comb begin
      f3_ok   = 1'b1;
      lane_ok = 1'b1;
      be      = 4'b0000;
      wd      = bus.req_wdata;
      case (op)
         LB, LBU, SB: begin
            be = 4'b0001 << bus.req_addr[1:0];
            wd = {4{bus.req_wdata[7:0]}};
         end
         LH, LHU, SH: begin
            be      = 4'b0011 << bus.req_addr[1:0];
            wd      = {2{bus.req_wdata[15:0]}};
            lane_ok = !bus.req_addr[0];
         end
         LW, SW: begin
            be      = 4'b1111;
            lane_ok = bus.req_addr[1:0] == 2'b00;
         end
         default: f3_ok = 1'b0;
      endcase
   end

   // Source word selection and little-endian load formatting
   always_comb begin
      rd_word = '0;
      if (is_ram)          rd_word = dmem[idx];
      else if (is_sw)      rd_word = {16'h0000, sw_sync};
      else if (is_led)     rd_word = {16'h0000, leds};
      else if (cnt_mapped) rd_word = cnt_val;
      sh_word = rd_word >> {bus.req_addr[1:0], 3'b000};
      case (op)
         LB:      ld_data = {{24{sh_word[7]}}, sh_word[7:0]};
         LH:      ld_data = {{16{sh_word[15]}}, sh_word[15:0]};
         LW:      ld_data = rd_word;
         LBU:     ld_data = {24'h000000, sh_word[7:0]};
         LHU:     ld_data = {16'h0000, sh_word[15:0]};
         default: ld_data = '0;
      endcase
   end

   // RAM byte-lane writes; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_ok && is_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) dmem[idx][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   // Handshake FSM, registered response and LED register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         leds    <= '0;
      end else begin
         if (state == ST_IDLE) state <= accept ? ST_RESP : ST_IDLE;
         else                  state <= ST_IDLE;
         rdata_q <= (accept && !req_err && !bus.req_we) ? ld_data : '0;
         err_q   <= accept && req_err;
         if (wr_ok && is_led) begin
            if (be[0]) leds[7:0]  <= wd[7:0];
            if (be[1]) leds[15:8] <= wd[15:8];
         end
      end
   end
endmodule

// File: tb/tb_data_mem_io.sv
// tb/tb_data_mem_io.sv - scoreboard bench for data_mem_io
module tb_data_mem_io;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] sw = 16'h0000;
   logic [15:0] leds;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          acc_cyc = 0;
   logic [32:0] sb_q[$];

   data_mem_io_if bus();

   data_mem_io #(.DMEM_WORDS(1024)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .boardSwitches (sw),
      .boardLEDs     (leds)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Issue one request, wait for acceptance, pop and compare the response one cycle later
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e,
                         input string name);
      int waited;
      logic [32:0] exp;
      waited = 0;
      sb_q.push_back({exp_e, exp_d});
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      while (bus.req_ready !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: req_ready=%b required 1", name, bus.req_ready);
         bus.req_valid = 1'b0;
         void'(sb_q.pop_front());
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      bus.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: rsp_valid=%b required 1", name, bus.rsp_valid);
      end
      exp = sb_q.pop_front();
      checks++;
      if ({bus.rsp_err, bus.rsp_rdata} !== exp) begin
         errors++;
         $display("FAIL %s rsp: err=%b rdata=%h required err=%b rdata=%h",
                  name, bus.rsp_err, bus.rsp_rdata, exp[32], exp[31:0]);
      end
   endtask

   // Unchecked load used where the expected value is relative
   task automatic raw_load(input logic [31:0] addr, output logic [31:0] d, output logic e,
                           output int at);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = addr;
      bus.req_wdata = '0;   bus.req_funct3 = 3'b010;
      while (bus.req_ready !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      at = cyc;
      bus.req_valid = 1'b0;
      @(negedge clk);
      d = bus.rsp_rdata;
      e = bus.rsp_err || !bus.rsp_valid;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.req_funct3 = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
          bus.rsp_err !== 1'b0 || leds !== 16'h0) begin
         errors++;
         $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b leds=%h required 1 0 0 0 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, leds);
      end
   endtask

   task automatic test_load_format();
      do_req(1, 32'h10, 32'h8000_00F1, 3'b010, 32'h0, 0, "sw_10");
      do_req(0, 32'h10, 0, 3'b000, 32'hFFFF_FFF1, 0, "lb_10");
      do_req(0, 32'h10, 0, 3'b100, 32'h0000_00F1, 0, "lbu_10");
      do_req(0, 32'h10, 0, 3'b001, 32'h0000_00F1, 0, "lh_10");
      do_req(0, 32'h10, 0, 3'b101, 32'h0000_00F1, 0, "lhu_10");
      do_req(0, 32'h10, 0, 3'b010, 32'h8000_00F1, 0, "lw_10");
      do_req(0, 32'h12, 0, 3'b001, 32'hFFFF_8000, 0, "lh_12");
      do_req(0, 32'h13, 0, 3'b100, 32'h0000_0080, 0, "lbu_13");
   endtask

   task automatic test_store_lanes();
      do_req(1, 32'h20, 32'h1122_3344, 3'b010, 32'h0, 0, "sw_20");
      do_req(1, 32'h22, 32'h0000_00AA, 3'b000, 32'h0, 0, "sb_22");
      do_req(0, 32'h20, 0, 3'b010, 32'h11AA_3344, 0, "lw_20a");
      do_req(1, 32'h21, 32'h0000_BEEF, 3'b001, 32'h0, 1, "sh_21_mis");
      do_req(0, 32'h20, 0, 3'b010, 32'h11AA_3344, 0, "lw_20b");
      do_req(1, 32'hFFC, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, "sw_last");
      do_req(0, 32'hFFC, 0, 3'b010, 32'hDEAD_BEEF, 0, "lw_last");
   endtask

   task automatic test_random_ram();
      logic [31:0] model[8];
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         do_req(1, 32'h100 + 32'(i * 4), model[i], 3'b010, 32'h0, 0, "rnd_sw");
      end
      for (int i = 7; i >= 0; i--)
         do_req(0, 32'h100 + 32'(i * 4), 0, 3'b010, model[i], 0, "rnd_lw");
   endtask

   task automatic test_switches();
      @(negedge clk);
      sw = 16'hA5A5;
      do_req(0, 32'h0010_0000, 0, 3'b010, 32'h0000_0000, 0, "sw_early");
      do_req(0, 32'h0010_0000, 0, 3'b010, 32'h0000_A5A5, 0, "sw_synced");
      do_req(1, 32'h0010_0000, 32'h1, 3'b010, 32'h0, 1, "sw_store");
   endtask

   task automatic test_leds();
      do_req(1, 32'h0010_0004, 32'hFFFF_1234, 3'b010, 32'h0, 0, "led_sw");
      checks++;
      if (leds !== 16'h1234) begin
         errors++;
         $display("FAIL led_sw leds: %h required 1234", leds);
      end
      do_req(1, 32'h0010_0005, 32'h0000_0056, 3'b000, 32'h0, 0, "led_sb");
      checks++;
      if (leds !== 16'h5634) begin
         errors++;
         $display("FAIL led_sb leds: %h required 5634", leds);
      end
      do_req(0, 32'h0010_0004, 0, 3'b010, 32'h0000_5634, 0, "led_lw");
   endtask

   task automatic test_errors();
      do_req(0, 32'h0020_0000, 0, 3'b010, 32'h0, 1, "unmapped");
      do_req(0, 32'h0000_1000, 0, 3'b010, 32'h0, 1, "ram_end");
      do_req(0, 32'h20, 0, 3'b011, 32'h0, 1, "bad_f3");
      do_req(1, 32'h20, 0, 3'b100, 32'h0, 1, "bad_st_f3");
      do_req(0, 32'h22, 0, 3'b010, 32'h0, 1, "lw_mis");
`ifndef DATA_MEM_IO_CYCLE_CNT_EN
      do_req(0, 32'h0010_0008, 0, 3'b010, 32'h0, 1, "cnt_absent");
`endif
   endtask

   task automatic test_cycle_cnt();
`ifdef DATA_MEM_IO_CYCLE_CNT_EN
      logic [31:0] d1, d2;
      logic        e1, e2;
      int          a1, a2;
      raw_load(32'h0010_0008, d1, e1, a1);
      repeat (5) @(negedge clk);
      raw_load(32'h0010_0008, d2, e2, a2);
      checks++;
      if (e1 !== 1'b0 || e2 !== 1'b0 || (d2 - d1) !== 32'(a2 - a1)) begin
         errors++;
         $display("FAIL cnt_delta: delta=%0d err=%b%b required delta=%0d err=00",
                  d2 - d1, e1, e2, a2 - a1);
      end
      do_req(1, 32'h0010_0008, 32'h5, 3'b010, 32'h0, 1, "cnt_store");
`endif
   endtask

   task automatic test_back_to_back();
      int first;
      do_req(1, 32'h40, 32'h0BAD_F00D, 3'b010, 32'h0, 0, "b2b_sw");
      first = acc_cyc;
      do_req(0, 32'h40, 0, 3'b010, 32'h0BAD_F00D, 0, "b2b_lw");
      checks++;
      if (acc_cyc - first !== 2) begin
         errors++;
         $display("FAIL b2b spacing: %0d cycles required 2", acc_cyc - first);
      end
   endtask

   task automatic test_reset_in_resp();
      do_req(1, 32'h0010_0004, 32'h0000_1234, 3'b010, 32'h0, 0, "rst_led_sw");
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || leds !== 16'h0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_resp: valid=%b leds=%h ready=%b required 0 0000 1",
                  bus.rsp_valid, leds, bus.req_ready);
      end
      rst = 1'b0;
      do_req(1, 32'h44, 32'hCAFE_0001, 3'b010, 32'h0, 0, "rst_ram_sw");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_req(0, 32'h44, 0, 3'b010, 32'hCAFE_0001, 0, "rst_ram_keep");
   endtask

   initial begin
      test_reset();
      test_load_format();
      test_store_lanes();
      test_random_ram();
      test_switches();
      test_leds();
      test_errors();
      test_cycle_cnt();
      test_back_to_back();
      test_reset_in_resp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
